// File: rtl/wavelet_window_ctrl.sv
// Raster-scan sequencer for the Haar wavelet front end: gates line-buffer shifts and
// issues one back-pressured 2x2 window strobe per completed block.
module wavelet_window_ctrl #(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      in_valid,
  input  logic                      in_sof,
  output logic                      in_ready,
  output logic                      shift_en,
  output logic [$clog2(WIDTH)-1:0]  col,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      win_valid,
  input  logic                      win_ready,
  output logic [$clog2(WIDTH)-2:0]  win_x,
  output logic [$clog2(HEIGHT)-2:0] win_y,
  output logic                      win_last,
  output logic                      busy,
  output logic                      err_sof
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
  localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StRowEven, StRowOdd, StDrain} state_e;

  state_e state_q;
  logic   in_row, stall, fire, at_origin, col_wrap;

  always_comb begin
    in_row    = (state_q == StRowEven) || (state_q == StRowOdd);
    stall     = win_valid & ~win_ready;
    // Gated by resetn so upstream never sees ready while the block is held in reset.
    in_ready  = resetn & ((state_q == StIdle) | (in_row & ~stall));
    fire      = in_valid & in_ready;
    shift_en  = fire & (in_row | ((state_q == StIdle) & in_sof));
    at_origin = (col == '0) && (row == '0);
    col_wrap  = (col == ColLast);
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      win_last  <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      err_sof <= 1'b0;
      if (win_valid && win_ready) win_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fire) begin
            if (in_sof) begin
              col     <= CW'(1);
              row     <= '0;
              state_q <= StRowEven;
            end else begin
              err_sof <= 1'b1;
            end
          end
        end
        StRowEven, StRowOdd: begin
          if (fire) begin
            if (in_sof && !at_origin) begin
              // Abort: this pixel restarts the frame; any pending window keeps its handshake.
              err_sof <= 1'b1;
              col     <= CW'(1);
              row     <= '0;
              state_q <= StRowEven;
            end else begin
              if (state_q == StRowOdd && col[0]) begin
                win_valid <= 1'b1;
                win_x     <= col[CW-1:1];
                win_y     <= row[RW-1:1];
                win_last  <= (row == RowLast) && col_wrap;
              end
              if (col_wrap) begin
                col <= '0;
                if (state_q == StRowEven) begin
                  row     <= row + RW'(1);
                  state_q <= StRowOdd;
                end else if (row == RowLast) begin
                  row     <= '0;
                  state_q <= StDrain;
                end else begin
                  row     <= row + RW'(1);
                  state_q <= StRowEven;
                end
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        StDrain: begin
          if (win_valid && win_ready && win_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
